// File: rtl/regfile_pkg.sv
// Shared definitions for the register file and the load-align stage:
// writeback size encodings and the sub-word extension helper.
package regfile_pkg;

  // Writeback size encodings
  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  // Width the extension helper works at; callers zero-pad narrower data
  // and keep the low bits of the result. Sign fill covers the whole width,
  // so truncation keeps the correct extension for any DATA_W <= EXT_W.
  localparam int EXT_W = 64;

  // Byte/half sign or zero extension; word passes through unchanged.
  function automatic logic [EXT_W-1:0] ext_data(input logic [1:0]       size,
                                                input logic             is_unsigned,
                                                input logic [EXT_W-1:0] data);
    logic [EXT_W-1:0] res;
    res = data;
    case (size)
      SZ_BYTE: res = {{(EXT_W-8){~is_unsigned & data[7]}}, data[7:0]};
      SZ_HALF: res = {{(EXT_W-16){~is_unsigned & data[15]}}, data[15:0]};
      default: res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for load-use hazard detection. A mark sets the
// bit, a qualifying writeback clears it; a mark to the same register in
// the same cycle wins because the newer producer is still outstanding.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int N_REGS = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mark_en_i,
  input  logic [ADDR_W-1:0] mark_addr_i,
  input  logic              clr_en_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  output logic [N_REGS-1:0] busy_o
);

  logic [N_REGS-1:0] busy_q;
  logic [N_REGS-1:0] busy_d;
  logic              mark_ok;

  // Register 0 is hardwired to zero and can never have a pending producer
  assign mark_ok = mark_en_i && (mark_addr_i != '0);

  genvar gi;
  generate
    for (gi = 0; gi < N_REGS; gi++) begin : g_bit
      logic set_hit;
      logic clr_hit;
      assign set_hit = mark_ok && (mark_addr_i == ADDR_W'(gi));
      assign clr_hit = clr_en_i && (clr_addr_i == ADDR_W'(gi));
      // Set takes priority over clear; marking a busy register keeps it busy
      always_comb begin
        busy_d[gi] = busy_q[gi];
        if (set_hit)      busy_d[gi] = 1'b1;
        else if (clr_hit) busy_d[gi] = 1'b0;
      end
    end
  endgenerate

  // Busy vector state register with synchronous clear
  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file for the pipelined core's decode stage.
// Combinational reads, one sub-word-capable write port, optional
// same-cycle write-to-read bypass and a busy scoreboard per register.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_REGS = 32,
  parameter int ADDR_W = 5,
  parameter int N_RD   = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr,
  output logic [N_RD*DATA_W-1:0]   rd_data,
  output logic [N_RD-1:0]          rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [1:0]               wr_size,
  input  logic                     wr_unsigned,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     mark_en,
  input  logic [ADDR_W-1:0]        mark_addr,
  output logic                     busy_any
);

  logic [DATA_W-1:0] regs_q [N_REGS];
  logic [EXT_W-1:0]  ext_full;
  logic [DATA_W-1:0] ext;
  logic              wr_qual;
  logic [N_REGS-1:0] busy_vec;

  // A write only happens for a real size and a non-zero destination
  assign wr_qual  = wr_en && (wr_size != SZ_NONE) && (wr_addr != '0);
  assign ext_full = ext_data(wr_size, wr_unsigned, EXT_W'(wr_data));
  assign ext      = ext_full[DATA_W-1:0];

  generate
    if (DATA_W < EXT_W) begin : g_pad
      // Upper bits of the wide helper result are not needed here
      logic pad_unused;
      assign pad_unused = ^ext_full[EXT_W-1:DATA_W];
    end
  endgenerate

  // Storage array: cleared by reset, which also discards a same-cycle write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_REGS; i++) regs_q[i] <= '0;
    end else if (wr_qual) begin
      regs_q[wr_addr] <= ext;
    end
  end

  regfile_scoreboard #(
    .N_REGS (N_REGS),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .mark_en_i   (mark_en),
    .mark_addr_i (mark_addr),
    .clr_en_i    (wr_qual),
    .clr_addr_i  (wr_addr),
    .busy_o      (busy_vec)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] raddr;
      logic              hit;
      assign raddr = rd_addr[gi*ADDR_W +: ADDR_W];
      // Bypass only when enabled; the forwarded value is the extended one
      assign hit   = (BYPASS != 0) && wr_qual && (raddr == wr_addr);
      // Read mux: r0 reads zero, a bypassed read is never reported busy
      always_comb begin
        rd_data[gi*DATA_W +: DATA_W] = regs_q[raddr];
        rd_busy[gi]                  = busy_vec[raddr] && !hit;
        if (raddr == '0) begin
          rd_data[gi*DATA_W +: DATA_W] = '0;
          rd_busy[gi]                  = 1'b0;
        end else if (hit) begin
          rd_data[gi*DATA_W +: DATA_W] = ext;
        end
      end
    end
  endgenerate

  assign busy_any = |rd_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing instance and one
// non-bypassing instance driven by the same stimulus.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data_b, rd_data_n;
  logic [1:0]  rd_busy_b, rd_busy_n;
  logic        busy_any_b, busy_any_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [1:0]  wr_size;
  logic        wr_unsigned;
  logic [31:0] wr_data;
  logic        mark_en;
  logic [4:0]  mark_addr;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(32), .N_REGS(32), .ADDR_W(5), .N_RD(2), .BYPASS(1)) u_dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_busy(rd_busy_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_size(wr_size),
    .wr_unsigned(wr_unsigned), .wr_data(wr_data), .mark_en(mark_en),
    .mark_addr(mark_addr), .busy_any(busy_any_b)
  );

  regfile_mp #(.DATA_W(32), .N_REGS(32), .ADDR_W(5), .N_RD(2), .BYPASS(0)) u_nobyp (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n),
    .rd_busy(rd_busy_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_size(wr_size),
    .wr_unsigned(wr_unsigned), .wr_data(wr_data), .mark_en(mark_en),
    .mark_addr(mark_addr), .busy_any(busy_any_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
      $display("check %s: observed %08h expected %08h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  // Advance past the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [1:0] sz,
                          input logic uns, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_size = sz; wr_unsigned = uns; wr_data = d;
    tick();
    wr_en = 1'b0; wr_size = 2'b00;
  endtask

  initial begin
    reset = 1'b1; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_size = 2'b00;
    wr_unsigned = 1'b0; wr_data = '0; mark_en = 1'b0; mark_addr = '0;
    tick();
    tick();
    reset = 1'b0;

    // 1. Reset state across all registers, two ports
    for (int i = 0; i < 16; i++) begin
      set_rd(5'(2*i), 5'(2*i+1));
      @(negedge clk);
      chk($sformatf("rst_p0_r%0d", 2*i), rd_data_b[31:0], 32'h0);
      chk($sformatf("rst_p1_r%0d", 2*i+1), rd_data_b[63:32], 32'h0);
      chk($sformatf("rst_busy_%0d", i), {30'b0, rd_busy_b}, 32'h0);
      tick();
    end
    @(negedge clk);
    chk("rst_busy_any", {31'b0, busy_any_b}, 32'h0);
    tick();

    do_write(5'd0, 2'b11, 1'b0, 32'hFFFFFFFF);
    set_rd(5'd0, 5'd0);
    @(negedge clk);
    chk("r0_stays_zero", rd_data_b[31:0], 32'h0);
    tick();

    // 2. Sub-word extension
    do_write(5'd5, 2'b01, 1'b0, 32'h000000F0);
    do_write(5'd6, 2'b10, 1'b1, 32'h1234ABCD);
    do_write(5'd7, 2'b11, 1'b0, 32'h98761234);
    do_write(5'd8, 2'b11, 1'b0, 32'hA5A5A5A5);
    do_write(5'd8, 2'b00, 1'b0, 32'h0000DEAD);
    do_write(5'd12, 2'b10, 1'b0, 32'h00008001);
    do_write(5'd13, 2'b01, 1'b1, 32'h000001FF);
    set_rd(5'd5, 5'd6);
    @(negedge clk);
    chk("byte_signed_r5", rd_data_b[31:0], 32'hFFFFFFF0);
    chk("half_unsigned_r6", rd_data_b[63:32], 32'h0000ABCD);
    tick();
    set_rd(5'd7, 5'd8);
    @(negedge clk);
    chk("word_r7", rd_data_b[31:0], 32'h98761234);
    chk("size00_no_write_r8", rd_data_b[63:32], 32'hA5A5A5A5);
    tick();
    set_rd(5'd12, 5'd13);
    @(negedge clk);
    chk("half_signed_r12", rd_data_b[31:0], 32'hFFFF8001);
    chk("byte_unsigned_r13", rd_data_b[63:32], 32'h000000FF);
    tick();

    // 3. Same-cycle bypass versus old value
    do_write(5'd9, 2'b11, 1'b0, 32'h00000011);
    set_rd(5'd7, 5'd9);
    wr_en = 1'b1; wr_addr = 5'd9; wr_size = 2'b11; wr_unsigned = 1'b0; wr_data = 32'h22;
    @(negedge clk);
    chk("byp_new_value", rd_data_b[63:32], 32'h00000022);
    chk("nobyp_old_value", rd_data_n[63:32], 32'h00000011);
    chk("byp_other_port", rd_data_b[31:0], 32'h98761234);
    tick();
    wr_en = 1'b0; wr_size = 2'b00;
    @(negedge clk);
    chk("nobyp_next_cycle", rd_data_n[63:32], 32'h00000022);
    chk("byp_next_cycle", rd_data_b[63:32], 32'h00000022);
    wr_en = 1'b1; wr_addr = 5'd9; wr_size = 2'b01; wr_unsigned = 1'b0; wr_data = 32'h00000080;
    #1;
    chk("byp_extended_value", rd_data_b[63:32], 32'hFFFFFF80);
    tick();
    wr_en = 1'b0; wr_size = 2'b00;

    // 4. Load-use scoreboard
    mark_en = 1'b1; mark_addr = 5'd3;
    tick();
    mark_en = 1'b0;
    set_rd(5'd3, 5'd0);
    @(negedge clk);
    chk("mark_rd_busy", {30'b0, rd_busy_b}, 32'h1);
    chk("mark_busy_any", {31'b0, busy_any_b}, 32'h1);
    tick();
    wr_en = 1'b1; wr_addr = 5'd3; wr_size = 2'b11; wr_data = 32'h5;
    @(negedge clk);
    chk("wr_cycle_busy_clear", {30'b0, rd_busy_b}, 32'h0);
    chk("wr_cycle_busy_any", {31'b0, busy_any_b}, 32'h0);
    chk("wr_cycle_bypass", rd_data_b[31:0], 32'h5);
    chk("nobyp_wr_cycle_busy", {30'b0, rd_busy_n}, 32'h1);
    tick();
    wr_en = 1'b0; wr_size = 2'b00;
    @(negedge clk);
    chk("after_wr_busy", {30'b0, rd_busy_b}, 32'h0);
    chk("after_wr_data", rd_data_b[31:0], 32'h5);
    chk("nobyp_after_wr_busy", {31'b0, busy_any_n}, 32'h0);
    tick();

    // 5. Mark/write collisions
    mark_en = 1'b1; mark_addr = 5'd4;
    do_write(5'd4, 2'b11, 1'b0, 32'h00000044);
    mark_en = 1'b0;
    set_rd(5'd4, 5'd0);
    @(negedge clk);
    chk("same_addr_data", rd_data_b[31:0], 32'h44);
    chk("same_addr_set_wins", {30'b0, rd_busy_b}, 32'h1);
    tick();
    mark_en = 1'b1; mark_addr = 5'd10;
    do_write(5'd11, 2'b11, 1'b0, 32'h00000077);
    mark_en = 1'b0;
    set_rd(5'd10, 5'd11);
    @(negedge clk);
    chk("diff_addr_busy", {30'b0, rd_busy_b}, 32'h1);
    chk("diff_addr_data", rd_data_b[63:32], 32'h77);
    tick();
    mark_en = 1'b1; mark_addr = 5'd10;
    tick();
    mark_en = 1'b0;
    do_write(5'd10, 2'b11, 1'b0, 32'h000000AA);
    set_rd(5'd10, 5'd10);
    @(negedge clk);
    chk("remark_single_clear", {30'b0, rd_busy_b}, 32'h0);
    chk("same_addr_two_ports", rd_data_b[63:32], 32'hAA);
    tick();

    // 6. Reset overrides a pending write and mark
    mark_en = 1'b1; mark_addr = 5'd5;
    tick();
    mark_en = 1'b1; mark_addr = 5'd6;
    reset = 1'b1;
    do_write(5'd5, 2'b11, 1'b0, 32'h12345678);
    reset = 1'b0; mark_en = 1'b0;
    set_rd(5'd5, 5'd6);
    @(negedge clk);
    chk("rst_r5_data", rd_data_b[31:0], 32'h0);
    chk("rst_r5_r6_busy", {30'b0, rd_busy_b}, 32'h0);
    chk("rst_r6_data", rd_data_b[63:32], 32'h0);
    tick();
    set_rd(5'd4, 5'd7);
    @(negedge clk);
    chk("rst_r4_busy_clear", {31'b0, busy_any_b}, 32'h0);
    chk("rst_r7_data", rd_data_b[63:32], 32'h0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
